serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 16, is the operand and result width in bits.
REQ-002 Parameter DIGIT, default 4, is the number of bits added per clock; WIDTH SHALL be an integer multiple of DIGIT, and 1 <= DIGIT <= WIDTH.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operands and control are valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 cin  input  1  carry-in, used when not subtracting.
REQ-010 sub  input  1  subtract select; the port exists only with SERIAL_ADDER_SUB_EN (see Configuration).
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of the MSB.
REQ-015 ovf  output  1  signed (two's-complement) overflow.
REQ-016 busy  output  1  high in RUN and DONE.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-019 Accept occurs on a clock edge in IDLE with in_valid=1; it captures a, b, the initial carry and sub into registers, loads the digit counter with N-1 (where N = WIDTH/DIGIT), and moves to RUN.
REQ-020 Each RUN cycle SHALL add DIGIT bits, LSB digit first, using the registered carry, and shift the digit into the result register from the MSB side; the carry register updates every RUN cycle.
REQ-021 When the counter is 0 in RUN, the next edge SHALL go to DONE.
REQ-022 Latency: with accept at edge 0, out_valid SHALL be high after edge N, so DONE is entered exactly N edges after accept.
REQ-023 In DONE, sum, cout and ovf SHALL hold stable until an edge with out_ready=1, which SHALL return the FSM to IDLE; no new accept is possible on that same edge.
REQ-024 cout SHALL be the carry out of bit WIDTH-1.
REQ-025 ovf SHALL be the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-026 The operand inputs SHALL be ignored outside the accept edge, and changing them during RUN SHALL have no effect.
REQ-027 DIGIT=WIDTH SHALL give N=1, i.e. one RUN cycle.

Reset
REQ-028 While rst_n=0: state is IDLE, counter, carry, result and operand registers are 0, and sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1.
REQ-029 Asserting reset mid-RUN or in DONE SHALL discard the operation; no out_valid SHALL follow.
REQ-030 The first accept is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro SERIAL_ADDER_SUB_EN: when defined, the sub port exists; sub=1 SHALL compute a + ~b + 1, with cin ignored and cout=1 meaning no borrow; sub=0 SHALL compute a + b + cin.
REQ-032 Without SERIAL_ADDER_SUB_EN, there is no sub port and the result is always a + b + cin.

Structure
REQ-033 Package serial_adder_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and the default WIDTH/DIGIT constants.
REQ-034 Sub-module fa_cell (1-bit full adder: a, b, cin -> s, cout) SHALL be instantiated DIGIT times as a ripple chain for the per-cycle digit.
REQ-035 An elaboration-time check SHALL fail when WIDTH % DIGIT != 0.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-036 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; out_valid rises exactly 4 edges after accept.
REQ-037 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-038 Hold out_ready=0 for 5 cycles in DONE -> sum, cout and ovf stay stable and in_ready stays 0; out_ready=1 -> IDLE on the next edge.
REQ-039 Drop rst_n after the 2nd RUN cycle -> outputs go to reset values immediately; after release, the next operation 0x1234+0x1111 -> sum=0x2345.
REQ-040 With SERIAL_ADDER_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
REQ-041 DIGIT=16: 0xA5A5+0x5A5A, cin=1 -> sum=0x0000, cout=1, with out_valid 1 edge after accept.

Source files
------------

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : serial_adder_pkg                                           |
// | Purpose : Shared FSM state type and default sizing for serial_adder  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fa_cell                                                    |
// | Purpose : One-bit full adder, chained to form the per-cycle digit    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : fa_cell
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : serial_adder                                               |
// | Purpose : Digit-serial adder; DIGIT bits per clock, LSB digit first, |
// |           valid/ready handshakes on both sides.                      |
// | Options : SERIAL_ADDER_SUB_EN adds the 'sub' port (a + ~b + 1).      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int c_N  = WIDTH / DIGIT;
  localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(c_N - 1);

  // Configuration sanity: the operand must split into whole digits.
  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_t            state_q, state_d;
  logic [c_CW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [WIDTH-1:0]  w_b_in;
  logic              w_cin_in;
  logic [DIGIT:0]    w_c;
  logic [DIGIT-1:0]  w_s;
  logic [WIDTH-1:0]  w_res_shift;

  // Subtraction is folded into the captured operand: invert b, force carry-in.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_in   = sub ? ~b   : b;
  assign w_cin_in = sub ? 1'b1 : cin;
`else
  assign w_b_in   = b;
  assign w_cin_in = cin;
`endif

  // Ripple chain for the current digit, fed by the registered carry.
  assign w_c[0] = carry_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    fa_cell u_fa (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .cin  (w_c[i]),
      .s    (w_s[i]),
      .cout (w_c[i+1])
    );
  end

  // New digit enters the result from the MSB side.
  if (DIGIT == WIDTH) begin : g_res_full
    assign w_res_shift = w_s;
  end else begin : g_res_shift
    assign w_res_shift = {w_s, res_q[WIDTH-1:DIGIT]};
  end

  // Next-state and datapath update; everything holds by default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = w_b_in;
          carry_d = w_cin_in;
          cnt_d   = c_CNT_LOAD;
          res_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = w_c[DIGIT];
        res_d   = w_res_shift;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // Last digit holds the MSB: capture its carry-out and overflow.
          cout_d  = w_c[DIGIT];
          ovf_d   = w_c[DIGIT] ^ w_c[DIGIT-1];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared by asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = res_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_serial_adder                                            |
// | Purpose : Scoreboard bench for serial_adder (16/4 and 16/16 builds)  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_serial_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic        sub = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        cin16 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic        sub16 = 1'b0;
`endif
  logic        out_valid16;
  logic        out_ready16 = 1'b1;
  logic [15:0] sum16;
  logic        cout16;
  logic        ovf16;
  logic        busy16;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub16),
`endif
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every result handed over is compared to the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got sum=0x%0h with empty scoreboard", sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
          n_err++;
          $display("FAIL result: got sum=0x%0h cout=%0b ovf=%0b expected sum=0x%0h cout=%0b ovf=%0b",
                   sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
      end
    end
  end

  // One operation: accept, latency check, optional DONE hold, handshake out.
  task automatic do_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                       input logic vs, input exp_t e, input int hold);
    int lat;
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = vs;
`else
    if (vs) $display("note: subtract vector issued without subtract build");
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin lat = k; break; end
    end
    chk("latency_edges", 32'(lat), 32'd4);
    for (int h = 0; h < hold; h++) begin
      chk("hold_sum", {16'd0, sum}, {16'd0, e.sum});
      chk("hold_flags", {29'd0, cout, ovf, in_ready}, {29'd0, e.cout, e.ovf, 1'b0});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("back_to_idle", {29'd0, in_ready, out_valid, busy}, {29'd0, 1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset_outputs", {16'd0, sum}, 32'd0);
    chk("reset_flags", {27'd0, cout, ovf, out_valid, busy, in_ready}, 32'd1);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}, 0);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b0, '{16'h0001, 1'b0, 1'b0}, 0);
    do_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0}, 0);
    do_op(16'h4000, 16'h4000, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}, 5);

    // Abort mid-RUN: reset after the second RUN cycle
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_sum", {16'd0, sum}, 32'd0);
    chk("abort_flags", {27'd0, cout, ovf, out_valid, busy, in_ready}, 32'd1);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("no_valid_after_abort", {30'd0, out_valid, in_ready}, 32'd1);
    end
    do_op(16'h1234, 16'h1111, 1'b0, 1'b0, '{16'h2345, 1'b0, 1'b0}, 0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0}, 0);
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, '{16'h0002, 1'b1, 1'b0}, 0);
`endif

    // Single-digit build: one RUN cycle
    a16 = 16'hA5A5; b16 = 16'h5A5A; cin16 = 1'b1; in_valid16 = 1'b1;
    @(posedge clk);
    #1 in_valid16 = 1'b0;
    chk("d16_not_yet_valid", {31'd0, out_valid16}, 32'd0);
    @(posedge clk);
    #1;
    chk("d16_valid_after_1", {31'd0, out_valid16}, 32'd1);
    chk("d16_sum", {16'd0, sum16}, 32'd0);
    chk("d16_flags", {30'd0, cout16, ovf16}, 32'd2);

    @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule : tb_serial_adder
`default_nettype wire
